// File: rtl/lsu_pkg.sv
// Shared types for the load/store sequencer: access-size and FSM state encodings,
// plus a helper giving the byte-lane footprint of each access size.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_D = 2'b00,
    SZ_W = 2'b01,
    SZ_H = 2'b10,
    SZ_B = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  localparam int MAX_MEM_LAT = 7;

  // Byte lanes covered by an access of the given size, starting at lane 0.
  function automatic logic [7:0] size_lanes(lsu_size_t sz);
    logic [7:0] lanes;
    case (sz)
      SZ_D:    lanes = 8'hFF;
      SZ_W:    lanes = 8'h0F;
      SZ_H:    lanes = 8'h03;
      SZ_B:    lanes = 8'h01;
      default: lanes = 8'h00;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: load extraction with sign/zero extension, sub-doubleword
// store merge, and the natural-alignment check used when a request is captured.
module byte_lane_unit
  import lsu_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [63:0] wdata,
  input  logic [2:0]  offset,
  input  lsu_size_t   size,
  input  logic        is_unsigned,
  input  logic [2:0]  chk_offset,
  input  lsu_size_t   chk_size,
  output logic [63:0] load_data,
  output logic [63:0] store_data,
  output logic        misaligned
);

  logic [5:0]  shamt;
  logic [63:0] lane;
  logic [63:0] wdata_sh;
  logic [7:0]  lane_en;

  assign shamt    = {offset, 3'b000};
  assign lane     = dword >> shamt;
  assign wdata_sh = wdata << shamt;
  assign lane_en  = size_lanes(size) << offset;

  always_comb begin
    load_data = lane;
    case (size)
      SZ_B:    load_data = is_unsigned ? {56'd0, lane[7:0]}  : {{56{lane[7]}}, lane[7:0]};
      SZ_H:    load_data = is_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      SZ_W:    load_data = is_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

  // Each byte of the new doubleword is either the shifted store byte or the old one.
  for (genvar gi = 0; gi < 8; gi++) begin : g_merge
    assign store_data[8*gi +: 8] = lane_en[gi] ? wdata_sh[8*gi +: 8] : dword[8*gi +: 8];
  end

  always_comb begin
    misaligned = 1'b0;
    case (chk_size)
      SZ_D:    misaligned = |chk_offset;
      SZ_W:    misaligned = |chk_offset[1:0];
      SZ_H:    misaligned = chk_offset[0];
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Multicycle load/store sequencer: aligned doubleword reads with lane extraction,
// read-modify-write for sub-doubleword stores, done/err handshake to the control unit.
module lsu_sequencer
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic [63:0] dmem_addr,
  output logic        dmem_wr,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  lsu_state_t  state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        write_reg, write_next;
  lsu_size_t   size_reg, size_next;
  logic        uns_reg, uns_next;
  logic [2:0]  off_reg, off_next;
  logic [63:0] wdata_reg, wdata_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        wr_reg, wr_next;
  logic [63:0] rdata_reg, rdata_next;
  logic [63:0] addr_reg, addr_next;
  logic [63:0] dwdata_reg, dwdata_next;

  logic [63:0] load_data;
  logic [63:0] store_data;
  logic        misaligned;

  byte_lane_unit u_lanes (
    .dword       (dmem_rdata),
    .wdata       (wdata_reg),
    .offset      (off_reg),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .chk_offset  (req_addr[2:0]),
    .chk_size    (lsu_size_t'(req_size)),
    .load_data   (load_data),
    .store_data  (store_data),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 3'd0;
      write_reg  <= 1'b0;
      size_reg   <= SZ_D;
      uns_reg    <= 1'b0;
      off_reg    <= 3'd0;
      wdata_reg  <= 64'd0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      wr_reg     <= 1'b0;
      rdata_reg  <= 64'd0;
      addr_reg   <= 64'd0;
      dwdata_reg <= 64'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      write_reg  <= write_next;
      size_reg   <= size_next;
      uns_reg    <= uns_next;
      off_reg    <= off_next;
      wdata_reg  <= wdata_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      wr_reg     <= wr_next;
      rdata_reg  <= rdata_next;
      addr_reg   <= addr_next;
      dwdata_reg <= dwdata_next;
    end
  end

  // Output registers are loaded on the edge that enters the state they belong to,
  // so done/err/dmem_wr line up exactly with RESP/WRITE.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    write_next  = write_reg;
    size_next   = size_reg;
    uns_next    = uns_reg;
    off_next    = off_reg;
    wdata_next  = wdata_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    wr_next     = 1'b0;
    rdata_next  = rdata_reg;
    addr_next   = addr_reg;
    dwdata_next = dwdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          write_next = req_write;
          size_next  = lsu_size_t'(req_size);
          uns_next   = req_unsigned;
          off_next   = req_addr[2:0];
          wdata_next = req_wdata;
          addr_next  = {req_addr[63:3], 3'b000};
          if (misaligned) begin
            state_next = ST_RESP;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end else if (req_write && (lsu_size_t'(req_size) == SZ_D)) begin
            state_next  = ST_WRITE;
            wr_next     = 1'b1;
            dwdata_next = req_wdata;
          end else begin
            state_next = ST_READ;
            cnt_next   = LAT_INIT;
          end
        end
      end
      ST_READ: begin
        if (cnt_reg == 3'd0) begin
          if (write_reg) begin
            state_next  = ST_WRITE;
            wr_next     = 1'b1;
            dwdata_next = store_data;
          end else begin
            state_next = ST_RESP;
            done_next  = 1'b1;
            rdata_next = load_data;
          end
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      ST_WRITE: begin
        state_next = ST_RESP;
        done_next  = 1'b1;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy       = (state_reg != ST_IDLE);
  assign done       = done_reg;
  assign err        = err_reg;
  assign rdata      = rdata_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_wr    = wr_reg;
  assign dmem_wdata = dwdata_reg;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer: directed table, corner-case sequences and
// random traffic checked against a byte-addressed reference memory model.
module tb_lsu_sequencer;

  localparam int ML = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rdata;
  logic [63:0] dmem_addr;
  logic        dmem_wr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;

  lsu_sequencer #(.MEM_LAT(ML)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .dmem_addr    (dmem_addr),
    .dmem_wr      (dmem_wr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: 32 doublewords, ML-cycle read pipeline.
  logic        mem_init;
  logic [63:0] mem [0:31];
  logic [63:0] rd_pipe [0:ML-1];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'd0;
      mem[8] <= 64'h8877665544332211;
    end else if (dmem_wr) begin
      mem[dmem_addr[7:3]] <= dmem_wdata;
    end
    rd_pipe[0] <= mem[dmem_addr[7:3]];
    for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign dmem_rdata = rd_pipe[ML-1];

  // Reference model: flat byte memory.
  logic [7:0] ref_mem [0:255];

  function automatic logic [63:0] model_load(logic [7:0] a, int nb, logic uns);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
    return v;
  endfunction

  function automatic logic [63:0] model_dword(logic [7:0] a);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 8; i++) v = v | (64'(ref_mem[int'({a[7:3], 3'b000}) + i]) << (8 * i));
    return v;
  endfunction

  task automatic model_store(logic [7:0] a, int nb, logic [63:0] wd);
    for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
  endtask

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  typedef struct {
    int          done_cyc;
    logic        err;
    logic [63:0] rdata;
    int          wrs;
    int          wr_cyc;
    logic [63:0] wdata;
    logic [63:0] waddr;
    logic [63:0] daddr;
    logic        busy_ok;
    logic        busy_after;
  } res_t;

  // Issue one request from an IDLE cycle; returns one cycle after RESP (IDLE again).
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] wd, output res_t r);
    r.done_cyc = -1; r.err = 1'b0; r.rdata = 64'd0; r.wrs = 0; r.wr_cyc = -1;
    r.wdata = 64'd0; r.waddr = 64'd0; r.daddr = 64'd0; r.busy_ok = 1'b1; r.busy_after = 1'b1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~a; req_wdata = {$urandom, $urandom};
    req_size = ~sz; req_unsigned = ~u; req_write = ~w;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (!busy) r.busy_ok = 1'b0;
      if (dmem_wr) begin r.wrs++; r.wr_cyc = n; r.wdata = dmem_wdata; r.waddr = dmem_addr; end
      if (done) begin r.done_cyc = n; r.err = err; r.rdata = rdata; r.daddr = dmem_addr; break; end
    end
    @(posedge clk); #1;
    r.busy_after = busy;
  endtask

  task automatic check_res(string tag, res_t r, int edone, logic eerr, logic [63:0] erd,
                           int ewrs, int ewrc, logic [63:0] ewd, logic [63:0] eaddr);
    chk({tag, ".done_cycle"}, 64'(r.done_cyc), 64'(edone));
    chk({tag, ".err"}, 64'(r.err), 64'(eerr));
    chk({tag, ".rdata"}, r.rdata, erd);
    chk({tag, ".write_count"}, 64'(r.wrs), 64'(ewrs));
    if (ewrs > 0) begin
      chk({tag, ".write_cycle"}, 64'(r.wr_cyc), 64'(ewrc));
      chk({tag, ".dmem_wdata"}, r.wdata, ewd);
      chk({tag, ".write_addr"}, r.waddr, eaddr);
    end
    if (!eerr) chk({tag, ".dmem_addr"}, r.daddr, eaddr);
    chk({tag, ".busy_during"}, 64'(r.busy_ok), 64'd1);
    chk({tag, ".busy_after"}, 64'(r.busy_after), 64'd0);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] erd;
    int          edone;
    logic        eerr;
    int          ewrs;
    int          ewrc;
    logic [63:0] ewd;
  } vec_t;

  vec_t tbl [15];

  initial begin
    res_t        r;
    logic [63:0] last_rd;
    logic [63:0] ewd;
    logic [63:0] erd;
    logic [7:0]  a8;
    logic [1:0]  sz;
    logic        w;
    logic        u;
    int          nb;
    int          dn;
    int          wr;

    tbl[0]  = '{1'b0, 2'd3, 1'b0, 64'h47, 64'h0, 64'hFFFFFFFFFFFFFF88, 3, 1'b0, 0, 0, 64'h0};
    tbl[1]  = '{1'b0, 2'd3, 1'b1, 64'h47, 64'h0, 64'h0000000000000088, 3, 1'b0, 0, 0, 64'h0};
    tbl[2]  = '{1'b0, 2'd1, 1'b0, 64'h44, 64'h0, 64'hFFFFFFFF88776655, 3, 1'b0, 0, 0, 64'h0};
    tbl[3]  = '{1'b1, 2'd2, 1'b0, 64'h42, 64'hABCD, 64'hFFFFFFFF88776655, 4, 1'b0, 1, 3,
                64'h88776655ABCD2211};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 64'h42, 64'h0, 64'hFFFFFFFFFFFFABCD, 3, 1'b0, 0, 0, 64'h0};
    tbl[5]  = '{1'b0, 2'd2, 1'b1, 64'h42, 64'h0, 64'h000000000000ABCD, 3, 1'b0, 0, 0, 64'h0};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 64'h48, 64'h0123456789ABCDEF, 64'h000000000000ABCD, 2, 1'b0, 1, 1,
                64'h0123456789ABCDEF};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 64'h42, 64'h0, 64'h000000000000ABCD, 1, 1'b1, 0, 0, 64'h0};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 64'h48, 64'h0, 64'h0123456789ABCDEF, 3, 1'b0, 0, 0, 64'h0};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 64'h4C, 64'h0, 64'h0000000001234567, 3, 1'b0, 0, 0, 64'h0};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 64'h4F, 64'hFFFFFFFFFFFFFF80, 64'h0000000001234567, 4, 1'b0, 1, 3,
                64'h8023456789ABCDEF};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 64'h4F, 64'h0, 64'hFFFFFFFFFFFFFF80, 3, 1'b0, 0, 0, 64'h0};
    tbl[12] = '{1'b1, 2'd0, 1'b0, 64'h44, 64'h1111, 64'hFFFFFFFFFFFFFF80, 1, 1'b1, 0, 0, 64'h0};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 64'h47, 64'h0, 64'hFFFFFFFFFFFFFF80, 1, 1'b1, 0, 0, 64'h0};
    tbl[14] = '{1'b0, 2'd1, 1'b1, 64'h40, 64'h0, 64'h00000000ABCD2211, 3, 1'b0, 0, 0, 64'h0};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) ref_mem[8'h40 + i] = 8'h11 * 8'(i + 1);

    mem_init = 1'b1; reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.err", 64'(err), 64'd0);
    chk("reset.dmem_wr", 64'(dmem_wr), 64'd0);
    chk("reset.rdata", rdata, 64'd0);
    chk("reset.dmem_addr", dmem_addr, 64'd0);
    chk("reset.dmem_wdata", dmem_wdata, 64'd0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      run_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr, tbl[i].wd, r);
      $display("vec %0d: w=%0d sz=%0d u=%0d addr=%h done@%0d err=%0d rdata=%h wrs=%0d",
               i, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr, r.done_cyc, r.err, r.rdata, r.wrs);
      check_res($sformatf("vec%0d", i), r, tbl[i].edone, tbl[i].eerr, tbl[i].erd,
                tbl[i].ewrs, tbl[i].ewrc, tbl[i].ewd, {tbl[i].addr[63:3], 3'b000});
      if (tbl[i].w && !tbl[i].eerr)
        model_store(tbl[i].addr[7:0], 8 >> tbl[i].sz, tbl[i].wd);
    end
    last_rd = tbl[14].erd;

    // Requests held high while busy (a store that would write) must be ignored.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 64'h40; req_wdata = 64'd0;
    @(posedge clk); #1;
    req_write = 1'b1; req_size = 2'd0; req_addr = 64'h40; req_wdata = 64'hDEADBEEFDEADBEEF;
    dn = 0; wr = 0;
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (dn > 0) req_valid = 1'b0;
      if (done) dn++;
      if (dmem_wr) wr++;
    end
    req_valid = 1'b0;
    last_rd = model_load(8'h40, 4, 1'b0);
    $display("busy-ignore: dones=%0d writes=%0d rdata=%h", dn, wr, rdata);
    chk("busy_ignore.done_count", 64'(dn), 64'd1);
    chk("busy_ignore.write_count", 64'(wr), 64'd0);
    chk("busy_ignore.rdata", rdata, last_rd);

    // Reset during the READ phase of a byte store.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h43; req_wdata = 64'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_abort.in_read_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_abort.busy", 64'(busy), 64'd0);
    dn = 0; wr = 0;
    for (int n = 0; n < 6; n++) begin
      if (done) dn++;
      if (dmem_wr) wr++;
      @(posedge clk); #1;
    end
    last_rd = 64'd0;
    $display("reset-abort: dones=%0d writes=%0d mem40=%h", dn, wr, mem[8]);
    chk("rst_abort.done_count", 64'(dn), 64'd0);
    chk("rst_abort.write_count", 64'(wr), 64'd0);
    chk("rst_abort.mem_unchanged", mem[8], model_dword(8'h40));
    chk("rst_abort.rdata_cleared", rdata, 64'd0);
    erd = model_load(8'h43, 1, 1'b0);
    run_req(1'b0, 2'd3, 1'b0, 64'h43, 64'd0, r);
    $display("after-reset lb 0x43: done@%0d rdata=%h", r.done_cyc, r.rdata);
    check_res("rst_abort.next_load", r, ML + 2, 1'b0, erd, 0, 0, 64'd0, 64'h40);
    last_rd = erd;

    // Random traffic against the byte model.
    for (int t = 0; t < 200; t++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      nb = 8 >> sz;
      a8 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a8 = a8 & ~8'(nb - 1);
      ewd = {$urandom, $urandom};
      run_req(w, sz, u, {56'd0, a8}, ewd, r);
      $display("rnd %0d: w=%0d sz=%0d u=%0d addr=%h done@%0d err=%0d rdata=%h wrs=%0d",
               t, w, sz, u, a8, r.done_cyc, r.err, r.rdata, r.wrs);
      if ((int'(a8) % nb) != 0) begin
        check_res($sformatf("rnd%0d", t), r, 1, 1'b1, last_rd, 0, 0, 64'd0, 64'd0);
      end else if (!w) begin
        last_rd = model_load(a8, nb, u);
        check_res($sformatf("rnd%0d", t), r, ML + 2, 1'b0, last_rd, 0, 0, 64'd0,
                  {56'd0, a8[7:3], 3'b000});
      end else begin
        model_store(a8, nb, ewd);
        check_res($sformatf("rnd%0d", t), r, (sz == 2'd0) ? 2 : ML + 3, 1'b0, last_rd, 1,
                  (sz == 2'd0) ? 1 : ML + 2, model_dword(a8), {56'd0, a8[7:3], 3'b000});
      end
    end

    for (int i = 0; i < 32; i++)
      chk($sformatf("final_mem[%0d]", i), mem[i], model_dword(8'(i * 8)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
